// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths, requester indices and FSM encoding for the exponentiation arbiter
package rsa_pkg;
  localparam int DATA_W_DEF = 1024;
  localparam int T_W_DEF = 10;
  localparam int CNT_W_DEF = 32;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
endpackage

// File: rtl/exp_arbiter_if.sv
// exp_arbiter_if: requester, response and core-side handshake bundle
interface exp_arbiter_if import rsa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_W = T_W_DEF
);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0][DATA_W-1:0] req_x, req_e, req_r, req_r2, req_m;
  logic [1:0][T_W-1:0] req_t;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic exp_start;
  logic [DATA_W-1:0] exp_x, exp_e, exp_r, exp_r2, exp_m;
  logic [T_W-1:0] exp_t;
  logic exp_done;
  logic [DATA_W-1:0] exp_result;
  modport slave (
    input req_valid, req_x, req_e, req_r, req_r2, req_m, req_t, rsp_ready, exp_done, exp_result,
    output req_ready, rsp_valid, rsp_data, exp_start, exp_x, exp_e, exp_r, exp_r2, exp_m, exp_t
  );
  modport master (
    output req_valid, req_x, req_e, req_r, req_r2, req_m, req_t, rsp_ready, exp_done, exp_result,
    input req_ready, rsp_valid, rsp_data, exp_start, exp_x, exp_e, exp_r, exp_r2, exp_m, exp_t
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, a tie goes to the index that did not own last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);
  // single requests pass through; a tie favours the non-pointer index
  always_comb grant = (&req) ? (pointer ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: shares one exponentiation core between two requesters
module exp_arbiter import rsa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_W = T_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  exp_arbiter_if.slave     bus,
  output logic             busy,
  output logic             last_owner,
  output logic [CNT_W-1:0] last_cycles
);
  state_t state;
  logic pointer, owner, gidx, accept;
  logic [1:0] grant;
  logic [CNT_W-1:0] cnt;
  rr_arb2 u_arb (.req(bus.req_valid), .pointer(pointer), .grant(grant));
  assign bus.req_ready = (state == IDLE && resetn) ? grant : 2'b00;
  assign gidx = grant[1];
  assign accept = |(bus.req_valid & bus.req_ready);
  assign bus.exp_start = state == START;
  assign bus.rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state != IDLE;
  // sequencing of accept, start pulse, cycle counting and response hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pointer <= REQ1;
      owner <= REQ0;
      cnt <= '0;
      last_owner <= REQ0;
      last_cycles <= '0;
      bus.rsp_data <= '0;
      bus.exp_x <= '0;
      bus.exp_e <= '0;
      bus.exp_r <= '0;
      bus.exp_r2 <= '0;
      bus.exp_m <= '0;
      bus.exp_t <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.exp_x <= bus.req_x[gidx];
          bus.exp_e <= bus.req_e[gidx];
          bus.exp_r <= bus.req_r[gidx];
          bus.exp_r2 <= bus.req_r2[gidx];
          bus.exp_m <= bus.req_m[gidx];
          bus.exp_t <= bus.req_t[gidx];
          owner <= gidx;
          state <= START;
        end
        START: begin
          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
          state <= BUSY;
        end
        BUSY: begin
          cnt <= &cnt ? cnt : cnt + 1'b1;
          if (bus.exp_done) begin
            bus.rsp_data <= bus.exp_result;
            last_cycles <= cnt;
            last_owner <= owner;
            pointer <= owner;
            state <= RESP;
          end
        end
        RESP: if (bus.rsp_ready[owner]) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: directed checks of arbitration, latency, back-pressure, reset and saturation
module tb_exp_arbiter;
  localparam int DW = 1024;
  localparam int TW = 10;
  logic clk = 0;
  logic resetn = 0;
  logic busy, last_owner, sbusy, slast_owner;
  logic [31:0] last_cycles;
  logic [3:0] slast_cycles;
  logic force_done = 0;
  logic [4:0] sh = '0;
  logic [19:0] sh2 = '0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  exp_arbiter_if #(.DATA_W(DW), .T_W(TW)) bus ();
  exp_arbiter_if #(.DATA_W(16), .T_W(4)) sbus ();
  exp_arbiter #(.DATA_W(DW), .T_W(TW), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .last_owner(last_owner), .last_cycles(last_cycles));
  exp_arbiter #(.DATA_W(16), .T_W(4), .CNT_W(4)) sdut (
    .clk(clk), .resetn(resetn), .bus(sbus), .busy(sbusy), .last_owner(slast_owner), .last_cycles(slast_cycles));
  // stub cores: done exactly L cycles after the start pulse, result is x+e
  always @(posedge clk) begin
    sh <= {sh[3:0], bus.exp_start};
    sh2 <= {sh2[18:0], sbus.exp_start};
  end
  assign bus.exp_done = sh[4] | force_done;
  assign bus.exp_result = bus.exp_x + bus.exp_e;
  assign sbus.exp_done = sh2[19];
  assign sbus.exp_result = sbus.exp_x + sbus.exp_e;

  task automatic idle_inputs();
    bus.req_valid = 0; bus.rsp_ready = 0;
    bus.req_x = '0; bus.req_e = '0; bus.req_r = '0; bus.req_r2 = '0; bus.req_m = '0; bus.req_t = '0;
    sbus.req_valid = 0; sbus.rsp_ready = 0;
    sbus.req_x = '0; sbus.req_e = '0; sbus.req_r = '0; sbus.req_r2 = '0; sbus.req_m = '0; sbus.req_t = '0;
  endtask

  task automatic do_reset();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic wait_rsp(output bit ok, output int starts);
    ok = 0; starts = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.exp_start) starts++;
      if (bus.rsp_valid != 0) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req_valid = 2'b01;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (bus.req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (bus.rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
    vecs++; if (bus.exp_start !== 1'b0) begin errs++; $display("FAIL reset_exp_start got %b want 0", bus.exp_start); end
    vecs++; if (last_owner !== 1'b0 || last_cycles !== 32'd0) begin errs++; $display("FAIL reset_last got %b/%0d want 0/0", last_owner, last_cycles); end
    vecs++; if (bus.rsp_data !== '0 || bus.exp_x !== '0) begin errs++; $display("FAIL reset_data got %0d/%0d want 0/0", bus.rsp_data, bus.exp_x); end
    bus.req_valid = 0;
    resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok; int starts;
    bus.req_x[0] = DW'(3); bus.req_e[0] = DW'(4); bus.req_valid = 2'b01;
    #1;
    vecs++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL single_ready got %b want 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 0;
    vecs++; if (bus.exp_start !== 1'b1 || bus.exp_x !== DW'(3)) begin errs++; $display("FAIL single_start got %b/%0d want 1/3", bus.exp_start, bus.exp_x); end
    wait_rsp(ok, starts);
    vecs++; if (!ok) begin errs++; $display("FAIL single_timeout got no rsp_valid want rsp_valid"); end
    vecs++; if (starts != 0) begin errs++; $display("FAIL single_extra_start got %0d want 0", starts); end
    vecs++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== DW'(7)) begin errs++; $display("FAIL single_rsp got %b/%0d want 01/7", bus.rsp_valid, bus.rsp_data); end
    vecs++; if (last_cycles !== 32'd5 || last_owner !== 1'b0) begin errs++; $display("FAIL single_last got %0d/%b want 5/0", last_cycles, last_owner); end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle got busy %b want 0", busy); end
  endtask

  task automatic test_tie();
    bit ok; int starts;
    do_reset();
    bus.req_x[0] = DW'(1); bus.req_e[0] = DW'(1);
    bus.req_x[1] = DW'(10); bus.req_e[1] = DW'(5);
    bus.req_valid = 2'b11;
    #1;
    vecs++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL tie1_ready got %b want 01", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    wait_rsp(ok, starts);
    vecs++; if (!ok || bus.rsp_valid !== 2'b01 || bus.rsp_data !== DW'(2) || last_owner !== 1'b0) begin
      errs++; $display("FAIL tie1_rsp got %b/%0d/%b want 01/2/0", bus.rsp_valid, bus.rsp_data, last_owner); end
    vecs++; if (bus.req_ready !== 2'b00) begin errs++; $display("FAIL tie1_resp_ready got %b want 00", bus.req_ready); end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    vecs++; if (bus.rsp_valid !== 2'b01) begin errs++; $display("FAIL tie1_nonowner_ready got %b want 01", bus.rsp_valid); end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    vecs++; if (bus.req_ready !== 2'b10) begin errs++; $display("FAIL tie2_ready got %b want 10", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_rsp(ok, starts);
    vecs++; if (!ok || bus.rsp_valid !== 2'b10 || bus.rsp_data !== DW'(15) || last_owner !== 1'b1) begin
      errs++; $display("FAIL tie2_rsp got %b/%0d/%b want 10/15/1", bus.rsp_valid, bus.rsp_data, last_owner); end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    bus.req_valid = 2'b11;
    #1;
    vecs++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL tie3_ready got %b want 01", bus.req_ready); end
    bus.req_valid = 0;
    @(posedge clk); #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL withdraw_busy got %b want 0", busy); end
  endtask

  task automatic test_back_pressure();
    bit ok; int starts; int bad_rsp = 0; int bad_ready = 0; int bad_start = 0;
    bus.req_x[1] = DW'(20); bus.req_e[1] = DW'(22); bus.req_valid = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_rsp(ok, starts);
    vecs++; if (!ok || bus.rsp_valid !== 2'b10 || bus.rsp_data !== DW'(42)) begin
      errs++; $display("FAIL bp_rsp got %b/%0d want 10/42", bus.rsp_valid, bus.rsp_data); end
    bus.req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== DW'(42)) bad_rsp++;
      if (bus.req_ready !== 2'b00) bad_ready++;
      if (bus.exp_start !== 1'b0) bad_start++;
    end
    vecs++; if (bad_rsp != 0) begin errs++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad_rsp); end
    vecs++; if (bad_ready != 0) begin errs++; $display("FAIL bp_ready got %0d ready cycles want 0", bad_ready); end
    vecs++; if (bad_start != 0) begin errs++; $display("FAIL bp_start got %0d start cycles want 0", bad_start); end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    vecs++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL bp_release_ready got %b want 01", bus.req_ready); end
    bus.req_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    bit ok; int starts;
    force_done = 1;
    @(posedge clk); #1;
    force_done = 0;
    vecs++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_data !== DW'(42)) begin
      errs++; $display("FAIL spur_idle got %b/%b/%0d want 0/00/42", busy, bus.rsp_valid, bus.rsp_data); end
    bus.req_x[0] = DW'(2); bus.req_e[0] = DW'(3); bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_rsp(ok, starts);
    vecs++; if (!ok || bus.rsp_data !== DW'(5)) begin errs++; $display("FAIL spur_op got %0d want 5", bus.rsp_data); end
    force_done = 1;
    @(posedge clk); #1;
    force_done = 0;
    vecs++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== DW'(5) || busy !== 1'b1 || last_cycles !== 32'd5) begin
      errs++; $display("FAIL spur_resp got %b/%0d/%b/%0d want 01/5/1/5", bus.rsp_valid, bus.rsp_data, busy, last_cycles); end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
  endtask

  task automatic test_reset_busy();
    bit ok; int starts; int seen = 0;
    bus.req_x[0] = DW'(7); bus.req_e[0] = DW'(8); bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 0;
    #1;
    vecs++; if (busy !== 1'b0 || bus.exp_start !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      errs++; $display("FAIL rstbusy_ctrl got %b/%b/%b want 0/0/00", busy, bus.exp_start, bus.rsp_valid); end
    vecs++; if (bus.exp_x !== '0 || bus.rsp_data !== '0 || last_cycles !== 32'd0 || last_owner !== 1'b0) begin
      errs++; $display("FAIL rstbusy_data got %0d/%0d/%0d/%b want 0/0/0/0", bus.exp_x, bus.rsp_data, last_cycles, last_owner); end
    #2;
    resetn = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL rstbusy_late_done got %0d active cycles want 0", seen); end
    bus.req_x[1] = DW'(100); bus.req_e[1] = DW'(1); bus.req_valid = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 0;
    wait_rsp(ok, starts);
    vecs++; if (!ok || bus.rsp_valid !== 2'b10 || bus.rsp_data !== DW'(101) || last_cycles !== 32'd5) begin
      errs++; $display("FAIL rstbusy_next got %b/%0d/%0d want 10/101/5", bus.rsp_valid, bus.rsp_data, last_cycles); end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
  endtask

  task automatic test_saturation();
    bit ok = 0;
    sbus.req_x[0] = 16'd3; sbus.req_e[0] = 16'd4; sbus.req_valid = 2'b01;
    @(posedge clk); #1;
    sbus.req_valid = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (sbus.rsp_valid != 0) ok = 1;
    end
    vecs++; if (!ok || slast_cycles !== 4'd15 || sbus.rsp_data !== 16'd7) begin
      errs++; $display("FAIL sat_cycles got %0d/%0d want 15/7", slast_cycles, sbus.rsp_data); end
    sbus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    sbus.rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_pressure();
    test_spurious();
    test_reset_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameters: DATA_W, default 1024, operand/result width; T_W, default 10, exponent bit-length field width; CNT_W, default 32, cycle-counter width.
REQ-002 Clock: one clock; reset is asynchronous and active-low; ports `clk` and `resetn`.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-requester request valid (index 0, 1).
REQ-006 req_ready  output  2  per-requester request accept.
REQ-007 req_x, req_e, req_r, req_r2, req_m  input  2xDATA_W each  per-requester operands.
REQ-008 req_t  input  2xT_W  per-requester exponent length.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_data  output  DATA_W  result, shared by both requesters, qualified by rsp_valid.
REQ-012 exp_start  output  1  one-cycle start pulse to the exponentiation core.
REQ-013 exp_x, exp_e, exp_r, exp_r2, exp_m  output  DATA_W each  latched operands to the core.
REQ-014 exp_t  output  T_W  latched length to the core.
REQ-015 exp_done  input  1  core completion, single-cycle.
REQ-016 exp_result  input  DATA_W  core result, valid with exp_done.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 last_owner  output  1  requester index of the most recently completed operation.
REQ-019 last_cycles  output  CNT_W  core cycles consumed by that operation.

Function
REQ-020 FSM states: IDLE, START, BUSY, RESP.
REQ-021 IDLE: the grant is combinational from req_valid and the priority pointer; req_ready is high only for the granted index, and only in IDLE.
REQ-022 Arbitration: if one request is valid, it is granted; if both are valid, the index not equal to the pointer is granted.
- The pointer holds the index of the last owner.
- After reset the pointer is 1, so requester 0 wins the first tie.
REQ-023 A request is accepted on an edge where req_valid&req_ready.
- On that edge, operands and t are registered into exp_*, the owner is recorded, and the FSM moves to START.
REQ-024 Requesters hold valid and operands stable until accepted; dropping valid before acceptance is legal and withdraws the request.
REQ-025 START: exp_start=1 for exactly one cycle, the cycle counter clears to 1, and the FSM goes to BUSY.
REQ-026 BUSY: the counter increments each cycle and saturates at all-ones.
- On exp_done, exp_result is registered into rsp_data, last_cycles takes the counter value, last_owner takes the owner, the pointer takes the owner, and the FSM goes to RESP.
REQ-027 RESP: rsp_valid[owner]=1, the other rsp_valid bit is 0, and rsp_data is stable.
- On rsp_ready[owner], the FSM goes to IDLE.
- rsp_ready of the non-owner is ignored.
REQ-028 Latency: acceptance at edge k gives exp_start high during cycle k+1; exp_done sampled at edge j gives rsp_valid high from cycle j+1.
REQ-029 exp_done in IDLE, START or RESP is ignored.
REQ-030 exp_start is never asserted outside START; at most one operation is in flight.
REQ-031 In RESP, a newly asserted req_valid receives no req_ready until IDLE is re-entered; rsp_valid has no back-to-back bypass.
REQ-032 exp_* outputs hold their value from acceptance until the next acceptance.

Reset
REQ-033 resetn low forces, asynchronously:
- FSM = IDLE, pointer = 1.
- req_ready = 0, rsp_valid = 0, exp_start = 0, busy = 0.
- last_owner = 0, last_cycles = 0, rsp_data = 0, exp_* = 0.
REQ-034 Reset mid-operation abandons the operation: no rsp_valid is issued, and a later exp_done from the core is ignored per REQ-029.

Structure
REQ-035 Shared package rsa_pkg holds the state encoding, DATA_W/T_W/CNT_W defaults and requester-index constants.
REQ-036 Round-robin grant logic is one sub-module, rr_arb2: inputs req[1:0] and pointer; output one-hot grant.

Verification
REQ-037 The bench uses a stub core that returns exp_x+exp_e exactly L=5 cycles after exp_start.
REQ-038 Single request: req_valid=01, x=3, e=4 -> req_ready[0] in the same cycle, one exp_start pulse, rsp_valid=01 with rsp_data=7, last_cycles=5, last_owner=0.
REQ-039 Tie after reset: req_valid=11 -> requester 0 is served first (x=1, e=1 -> 2), then requester 1 (x=10, e=5 -> 15); the next tie is granted to 0 again.
REQ-040 Back-pressure: hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stay stable, req_ready stays 0 throughout, and no exp_start is issued.
REQ-041 Spurious done: pulse exp_done in IDLE and in RESP -> no state change and rsp_data unchanged.
REQ-042 Reset in BUSY at cycle 2 -> all outputs reach reset values immediately; the stub's later exp_done produces no rsp_valid; the next request is then served normally.
REQ-043 Saturation: CNT_W=4 with stub L=20 -> last_cycles=15.
